// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// One tx_start per granted byte; waits for tx_done (or watchdog abort) before re-arbitrating.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef logic [ID_W-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  localparam idx_t            LAST_IDX = idx_t'(NUM_REQ - 1);
  // Outputs are registered, so the abort is decided one cycle before timeout_err shows.
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 2);

  state_t            state, state_nxt;
  idx_t              last_grant, last_d;
  logic [WD_W-1:0]   wdog, wdog_d;
  logic              wd_expired;

  logic [DATA_W-1:0] req_bytes [NUM_REQ];
  logic              pick_valid;
  idx_t              pick_idx;
  idx_t              cand;

  logic              start_d, terr_d;
  logic [NUM_REQ-1:0] ack_d, done_d;
  idx_t              grant_d;
  logic [DATA_W-1:0] data_d;

  assign wd_expired = (wdog == WD_LAST);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan from last_grant+1 with wrap so the requester just served ranks last.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + idx_t'(1);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pick_valid && !tx_busy) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (tx_done || wd_expired) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and bookkeeping.
  always_comb begin
    start_d = 1'b0;
    ack_d   = '0;
    done_d  = '0;
    terr_d  = 1'b0;
    grant_d = grant_id;
    data_d  = tx_data;
    last_d  = last_grant;
    wdog_d  = wdog;
    case (state)
      S_IDLE: begin
        if (pick_valid && !tx_busy) begin
          start_d         = 1'b1;
          ack_d[pick_idx] = 1'b1;
          grant_d         = pick_idx;
          data_d          = req_bytes[pick_idx];
        end
      end
      S_LAUNCH: wdog_d = '0;
      S_WAIT: begin
        wdog_d = wdog + 1'b1;
        // tx_done takes precedence over a watchdog expiring in the same cycle.
        if (tx_done) begin
          done_d[grant_id] = 1'b1;
          last_d           = grant_id;
        end else if (wd_expired) begin
          terr_d = 1'b1;
          last_d = grant_id;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ack     <= '0;
      req_done    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= LAST_IDX;
      wdog        <= '0;
    end else begin
      req_ack     <= ack_d;
      req_done    <= done_d;
      tx_start    <= start_d;
      tx_data     <= data_d;
      grant_id    <= grant_d;
      busy        <= (state_nxt != S_IDLE);
      timeout_err <= terr_d;
      last_grant  <= last_d;
      wdog        <= wdog_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scenario tasks plus a timestamp-based reference model
// compared against every output on every cycle.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int T  = 256;  // watchdog shortened so frames and aborts stay brief

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack, req_done;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy, tx_done;
  logic [1:0]      grant_id;
  logic            busy, timeout_err;
  logic [DW-1:0]   bytes_q [N];

  always_comb req_data = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  // Reference model: a frame is described by the cycle it was granted in.
  bit          m_free = 1'b1;
  int          m_gc, m_g;
  int          m_last = N - 1;
  logic        exp_start, exp_terr, exp_busy;
  logic [N-1:0] exp_ack, exp_done;
  logic [1:0]  exp_grant;
  logic [DW-1:0] exp_data;

  // Transmitter model and requester behaviour
  bit tx_auto  = 1'b1;
  bit tx_stall = 1'b0;
  bit rearm    = 1'b0;
  int tx_cnt   = -1;
  int frame_len = 4;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (((r >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    exp_start = 1'b0;
    exp_ack   = '0;
    exp_done  = '0;
    exp_terr  = 1'b0;
    if (rst) begin
      m_free    = 1'b1;
      m_last    = N - 1;
      exp_grant = '0;
      exp_data  = '0;
    end else if (m_free) begin
      if (req != '0 && !tx_busy) begin
        int w;
        w         = rr_pick(req, m_last);
        exp_start = 1'b1;
        exp_ack   = 4'b0001 << w;
        exp_grant = w[1:0];
        exp_data  = bytes_q[w[1:0]];
        m_g       = w;
        m_gc      = cyc;
        m_free    = 1'b0;
      end
    end else if (cyc - m_gc >= 2) begin
      if (tx_done) begin
        exp_done = 4'b0001 << m_g;
        m_last   = m_g;
        m_free   = 1'b1;
      end else if (cyc - m_gc == T) begin
        exp_terr = 1'b1;
        m_last   = m_g;
        m_free   = 1'b1;
      end
    end
    exp_busy = ~m_free;
  endtask

  // One clock: apply inputs, predict, compare all outputs, react as TX core and requesters.
  task automatic tick();
    if (tx_auto) begin
      tx_done = (tx_cnt == 0);
      tx_busy = (tx_cnt > 0);
    end
    model_step();
    @(negedge clk);
    n_assert++;
    if ({tx_start, req_ack, req_done, timeout_err, grant_id, tx_data, busy} !==
        {exp_start, exp_ack, exp_done, exp_terr, exp_grant, exp_data, exp_busy}) begin
      n_fail++;
      $display("FAIL model cyc %0d: got start=%b ack=%b done=%b terr=%b gid=%0d data=%h busy=%b, want start=%b ack=%b done=%b terr=%b gid=%0d data=%h busy=%b",
               cyc, tx_start, req_ack, req_done, timeout_err, grant_id, tx_data, busy,
               exp_start, exp_ack, exp_done, exp_terr, exp_grant, exp_data, exp_busy);
    end
    cyc++;
    if (tx_cnt >= 0) tx_cnt--;
    if (tx_start === 1'b1) tx_cnt = tx_stall ? -1 : frame_len;
    for (int i = 0; i < N; i++) if (req_ack[i] === 1'b1) req[i] = rearm;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    tx_cnt = -1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || req != '0) && n < budget) begin
      tick();
      n++;
    end
    n_assert++;
    if (busy !== 1'b0 || req != '0) begin
      n_fail++;
      $display("FAIL %s idle bound: busy=%b req=%b after %0d cycles, required busy=0 req=0", tag, busy, req, budget);
    end
  endtask

  task automatic test_reset();
    bit quiet;
    quiet = 1'b1;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) bytes_q[i] = 8'h10 + 8'(i);
    repeat (5) begin
      tick();
      if (tx_start !== 1'b0 || req_ack !== '0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_assert++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL reset_quiet: activity seen during reset, required none");
    end
    rst = 1'b0;
    tick();
    n_assert++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0 || req_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: start=%b gid=%0d ack=%b, required 1/0/0001", tx_start, grant_id, req_ack);
    end
    frame_len = 3;
    req = '0;
    wait_idle("reset", 50);
  endtask

  task automatic test_single();
    int  n;
    bit  data_ok;
    reset_dut();
    frame_len  = 200;
    bytes_q[2] = 8'hA5;
    req        = 4'b0100;
    tick();
    n_assert++;
    if (tx_start !== 1'b1 || req_ack !== 4'b0100 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_launch: start=%b ack=%b data=%h, required 1/0100/a5", tx_start, req_ack, tx_data);
    end
    bytes_q[2] = 8'h5A;
    n = 0;
    data_ok = 1'b1;
    while (req_done === '0 && n < 400) begin
      tick();
      n++;
      if (tx_data !== 8'hA5) data_ok = 1'b0;
    end
    n_assert++;
    if (req_done !== 4'b0100 || n != 201) begin
      n_fail++;
      $display("FAIL single_done: done=%b after %0d cycles, required 0100 after 201", req_done, n);
    end
    n_assert++;
    if (!data_ok) begin
      n_fail++;
      $display("FAIL single_data_stable: tx_data moved during frame, required a5 throughout");
    end
  endtask

  task automatic test_round_robin();
    int            ids[$];
    logic [DW-1:0] dat[$];
    int            n;
    reset_dut();
    for (int i = 0; i < N; i++) bytes_q[i] = 8'h10 + 8'(i);
    frame_len = 3;
    rearm = 1'b1;
    req = 4'b1111;
    n = 0;
    while (ids.size() < 6 && n < 300) begin
      tick();
      n++;
      if (tx_start === 1'b1) begin
        ids.push_back(int'(grant_id));
        dat.push_back(tx_data);
      end
    end
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] eb;
      eb = 8'h10 + 8'(k % 4);
      n_assert++;
      if (k >= ids.size()) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: no grant seen, required id %0d", k, k % 4);
      end else if (ids[k] != k % 4 || dat[k] !== eb) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: id=%0d data=%h, required id=%0d data=%h", k, ids[k], dat[k], k % 4, eb);
      end
    end
    rearm = 1'b0;
    req = '0;
    wait_idle("rr", 50);
  endtask

  task automatic test_watchdog();
    int n;
    bit saw_done, saw_terr;
    reset_dut();
    tx_stall = 1'b1;
    bytes_q[1] = 8'h21;
    bytes_q[2] = 8'h22;
    req = 4'b0110;
    tick();
    n_assert++;
    if (tx_start !== 1'b1 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL wd_first_grant: start=%b gid=%0d, required 1/1", tx_start, grant_id);
    end
    n = 0;
    saw_done = 1'b0;
    while (timeout_err !== 1'b1 && n < T + 20) begin
      tick();
      n++;
      if (req_done !== '0) saw_done = 1'b1;
    end
    n_assert++;
    if (timeout_err !== 1'b1 || n != T) begin
      n_fail++;
      $display("FAIL wd_latency: timeout_err=%b after %0d cycles, required 1 after %0d", timeout_err, n, T);
    end
    n_assert++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL wd_no_done: req_done seen for aborted frame, required none");
    end
    n = 0;
    while (tx_start !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n_assert++;
    if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL wd_next_grant: start=%b gid=%0d data=%h, required 1/2/22", tx_start, grant_id, tx_data);
    end
    wait_idle("wd_abort2", T + 20);
    // tx_done landing on the expiry cycle must complete the frame normally.
    tx_stall   = 1'b0;
    frame_len  = T - 1;
    bytes_q[0] = 8'h20;
    req        = 4'b0001;
    tick();
    n = 0;
    saw_terr = 1'b0;
    while (req_done === '0 && n < T + 20) begin
      tick();
      n++;
      if (timeout_err !== 1'b0) saw_terr = 1'b1;
    end
    n_assert++;
    if (req_done !== 4'b0001 || n != T || saw_terr) begin
      n_fail++;
      $display("FAIL wd_tie: done=%b at %0d cycles terr_seen=%b, required 0001 at %0d with no terr", req_done, n, saw_terr, T);
    end
    wait_idle("wd_tie", 20);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit saw_done;
    reset_dut();
    frame_len  = 100;
    bytes_q[1] = 8'h31;
    req = 4'b0010;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_assert++;
    if ({tx_start, req_ack, req_done, timeout_err, grant_id, tx_data, busy} !== '0) begin
      n_fail++;
      $display("FAIL midrst_zero: start=%b ack=%b done=%b terr=%b gid=%0d data=%h busy=%b, required all 0",
               tx_start, req_ack, req_done, timeout_err, grant_id, tx_data, busy);
    end
    frame_len  = 5;
    bytes_q[0] = 8'h30;
    req = 4'b0011;
    n = 0;
    saw_done = 1'b0;
    while (tx_start !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (req_done !== '0) saw_done = 1'b1;
    end
    n_assert++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0 || saw_done) begin
      n_fail++;
      $display("FAIL midrst_next: start=%b gid=%0d stray_done=%b, required 1/0/0", tx_start, grant_id, saw_done);
    end
    wait_idle("midrst", 100);
  endtask

  task automatic test_withdraw_busy();
    bit quiet;
    reset_dut();
    tx_auto = 1'b0;
    tx_busy = 1'b1;
    tx_done = 1'b0;
    quiet = 1'b1;
    req = 4'b1000;
    tick();
    if (tx_start !== 1'b0 || req_ack !== '0) quiet = 1'b0;
    req = 4'b0000;
    repeat (3) begin
      tick();
      if (tx_start !== 1'b0 || req_ack !== '0) quiet = 1'b0;
    end
    bytes_q[1] = 8'h41;
    req = 4'b0010;
    repeat (3) begin
      tick();
      if (tx_start !== 1'b0 || req_ack !== '0) quiet = 1'b0;
    end
    n_assert++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL busy_hold: grant issued while tx_busy high or after withdraw, required none");
    end
    tx_busy = 1'b0;
    tick();
    n_assert++;
    if (tx_start !== 1'b1 || grant_id !== 2'd1 || req_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL busy_release: start=%b gid=%0d ack=%b, required 1/1/0010", tx_start, grant_id, req_ack);
    end
    tx_busy = 1'b1;
    tick();
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    n_assert++;
    if (req_done !== 4'b0010) begin
      n_fail++;
      $display("FAIL busy_done: req_done=%b, required 0010", req_done);
    end
    tx_done = 1'b0;
    tick();
    tx_auto = 1'b1;
    tx_cnt  = -1;
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      frame_len = $urandom_range(0, T + 20);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            bytes_q[i] = 8'($urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0;
    req = '0;
    wait_idle("random", 2 * T + 100);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < N; i++) bytes_q[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_reset_mid_frame();
    test_withdraw_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
